// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC select encoding for the PC unit
package pc_pkg;

  localparam int          PC_ADDR_W    = 16;
  localparam int          PC_INC       = 2;
  localparam logic [15:0] PC_RESET_VEC = 16'h0000;
  localparam int          PC_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count and sticky ovf/unf flags
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [CW-1:0] count;

  assign ptr_inc  = ptr + PW'(1);
  assign top_data = mem[ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  // A push while full lands on the oldest slot, so the stack degrades to the newest DEPTH returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      mem[ptr_inc] <= push_data;
      ptr          <= ptr_inc;
      if (full) ovf <= 1'b1;
      else      count <= count + CW'(1);
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC register with branch/call/return next-PC and RAS; PC_HALT_EN adds halt
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = PC_ADDR_W,
  parameter int                INC       = PC_INC,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int                RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              halted
);

  pc_sel_e           sel;
  logic              active;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus_inc = pc + ADDR_W'(INC);

  always_comb begin
    sel = SEL_SEQ;
    if (ret)           sel = SEL_RET;
    else if (call)     sel = SEL_CALL;
    else if (br_taken) sel = SEL_BR;
  end

`ifdef PC_HALT_EN
  logic halted_q;

  // Halt outranks every redirect and, once taken, freezes the unit until reset.
  assign active = !stall && !halted_q && !halt;
  assign halted = halted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              halted_q <= 1'b0;
    else if (!stall && halt) halted_q <= 1'b1;
  end
`else
  logic unused_halt;

  assign unused_halt = halt;
  assign active      = !stall;
  assign halted      = 1'b0;
`endif

  always_comb begin
    next_pc = pc_plus_inc;
    case (sel)
      SEL_RET:  next_pc = ras_empty ? pc_plus_inc : ras_top;
      SEL_CALL: next_pc = br_target;
      SEL_BR:   next_pc = br_target;
      default:  next_pc = pc_plus_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pc <= RESET_VEC;
    else if (active) pc <= next_pc;
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (active && (sel == SEL_CALL)),
    .pop       (active && (sel == SEL_RET)),
    .push_data (pc_plus_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;

`ifdef PC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
  logic [15:0] br_target = 16'h0;
  logic [15:0] pc, pc_plus_inc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC plus a bounded LIFO of return addresses.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf, m_unf, m_halted;

  pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .call        (call),
    .ret         (ret),
    .halt        (halt),
    .pc          (pc),
    .pc_plus_inc (pc_plus_inc),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic model_step();
    if (stall) return;
    if (HALT_EN && m_halted) return;
    if (HALT_EN && halt) begin
      m_halted = 1'b1;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = m_pc + 16'd2;
        m_unf = 1'b1;
      end
    end else if (call) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(m_pc + 16'd2);
      m_pc = br_target;
    end else if (br_taken) begin
      m_pc = br_target;
    end else begin
      m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic cyc(input logic st, input logic br, input logic [15:0] tgt,
                     input logic cl, input logic rt, input logic hl);
    stall = st; br_taken = br; br_target = tgt; call = cl; ret = rt; halt = hl;
    model_step();
    @(posedge clk);
    #1;
    stall = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (pc !== 16'h0000 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_ovf !== 1'b0
        || ras_unf !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pc=%h empty=%b full=%b ovf=%b unf=%b halted=%b expected pc=0000 1 0 0 0 0",
               pc, ras_empty, ras_full, ras_ovf, ras_unf, halted);
    end
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    logic [15:0] exp;
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 16'h0, 0, 0, 0);
      exp = 16'(2 * i);
      n_checks++;
      if (pc !== exp || ras_empty !== 1'b1 || pc_plus_inc !== exp + 16'd2) begin
        n_fail++;
        $display("FAIL free_run[%0d]: pc=%h inc=%h empty=%b expected pc=%h inc=%h empty=1",
                 i, pc, pc_plus_inc, ras_empty, exp, exp + 16'd2);
      end
    end
  endtask

  task automatic test_call_ret();
    cyc(0, 1, 16'h0010, 0, 0, 0);
    cyc(0, 0, 16'h0100, 1, 0, 0);
    n_checks++;
    if (pc !== 16'h0100 || ras_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL call: pc=%h empty=%b expected pc=0100 empty=0", pc, ras_empty);
    end
    cyc(0, 0, 16'h0, 0, 1, 0);
    n_checks++;
    if (pc !== 16'h0012 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ret: pc=%h empty=%b expected pc=0012 empty=1", pc, ras_empty);
    end
  endtask

  task automatic test_nested();
    logic [15:0] rets [4];
    rets = '{16'h0402, 16'h0302, 16'h0202, 16'h0102};
    cyc(0, 1, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 16'((i + 1) * 16'h0100), 1, 0, 0);
      n_checks++;
      if (pc !== 16'((i + 1) * 16'h0100) || ras_full !== (i >= 3) || ras_ovf !== (i == 4)) begin
        n_fail++;
        $display("FAIL nested_call[%0d]: pc=%h full=%b ovf=%b expected pc=%h full=%b ovf=%b",
                 i, pc, ras_full, ras_ovf, 16'((i + 1) * 16'h0100), i >= 3, i == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 16'h0, 0, 1, 0);
      n_checks++;
      if (pc !== rets[i] || ras_unf !== 1'b0) begin
        n_fail++;
        $display("FAIL nested_ret[%0d]: pc=%h unf=%b expected pc=%h unf=0", i, pc, ras_unf, rets[i]);
      end
    end
    cyc(0, 0, 16'h0, 0, 1, 0);
    n_checks++;
    if (pc !== 16'h0104 || ras_unf !== 1'b1 || ras_empty !== 1'b1 || ras_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: pc=%h unf=%b empty=%b ovf=%b expected pc=0104 1 1 1",
               pc, ras_unf, ras_empty, ras_ovf);
    end
  endtask

  task automatic test_wrap_stall();
    cyc(0, 1, 16'hFFFE, 0, 0, 0);
    n_checks++;
    if (pc_plus_inc !== 16'h0000) begin
      n_fail++;
      $display("FAIL inc_wrap: pc_plus_inc=%h expected 0000", pc_plus_inc);
    end
    cyc(0, 0, 16'h0, 0, 0, 0);
    n_checks++;
    if (pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: pc=%h expected 0000", pc);
    end
    cyc(0, 0, 16'h0300, 1, 0, 0);
    cyc(1, 0, 16'h0777, 1, 0, 0);
    n_checks++;
    if (pc !== 16'h0300 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_call: pc=%h empty=%b full=%b expected pc=0300 0 0", pc, ras_empty, ras_full);
    end
    cyc(0, 0, 16'h0, 0, 1, 0);
    n_checks++;
    if (pc !== 16'h0002 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ret: pc=%h empty=%b expected pc=0002 empty=1", pc, ras_empty);
    end
  endtask

  task automatic test_priority();
    cyc(0, 1, 16'h0040, 0, 0, 0);
    cyc(0, 0, 16'h0200, 1, 0, 0);
    cyc(0, 1, 16'h0999, 1, 1, 0);
    n_checks++;
    if (pc !== 16'h0042 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_wins: pc=%h empty=%b expected pc=0042 empty=1", pc, ras_empty);
    end
    cyc(0, 1, 16'h0888, 1, 0, 0);
    n_checks++;
    if (pc !== 16'h0888 || ras_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL call_over_br: pc=%h empty=%b expected pc=0888 empty=0", pc, ras_empty);
    end
    cyc(0, 0, 16'h0, 0, 1, 0);
    n_checks++;
    if (pc !== 16'h0044) begin
      n_fail++;
      $display("FAIL call_over_br_ret: pc=%h expected 0044", pc);
    end
  endtask

  task automatic test_halt();
    cyc(0, 1, 16'h0020, 0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0, 1);
`ifdef PC_HALT_EN
    n_checks++;
    if (pc !== 16'h0020 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt: pc=%h halted=%b expected pc=0020 halted=1", pc, halted);
    end
    cyc(0, 1, 16'h0500, 0, 0, 0);
    cyc(0, 0, 16'h0600, 1, 0, 0);
    n_checks++;
    if (pc !== 16'h0020 || halted !== 1'b1 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_hold: pc=%h halted=%b empty=%b expected pc=0020 1 1", pc, halted, ras_empty);
    end
`else
    n_checks++;
    if (pc !== 16'h0022 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_ignored: pc=%h halted=%b expected pc=0022 halted=0", pc, halted);
    end
`endif
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 16'h0A00, 1, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pc !== 16'h0000 || ras_empty !== 1'b1 || ras_ovf !== 1'b0 || ras_unf !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h empty=%b ovf=%b unf=%b halted=%b expected 0000 1 0 0 0",
               pc, ras_empty, ras_ovf, ras_unf, halted);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(7) == 0, $urandom_range(3) == 0, 16'($urandom),
          $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(99) == 0);
      n_checks++;
      if (pc !== m_pc || pc_plus_inc !== m_pc + 16'd2 || ras_empty !== (m_ras.size() == 0)
          || ras_full !== (m_ras.size() == DEPTH) || ras_ovf !== m_ovf || ras_unf !== m_unf
          || halted !== m_halted) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h inc=%h e=%b f=%b o=%b u=%b h=%b expected pc=%h inc=%h e=%b f=%b o=%b u=%b h=%b",
                 i, pc, pc_plus_inc, ras_empty, ras_full, ras_ovf, ras_unf, halted,
                 m_pc, m_pc + 16'd2, m_ras.size() == 0, m_ras.size() == DEPTH, m_ovf, m_unf, m_halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_call_ret();
    test_nested();
    test_wrap_stall();
    test_priority();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
